// File: rtl/sd_cmd_master.sv
// Command-path sequencer: frames SD commands for the CMD-line serial host and supervises the response.
// Optional index check is compiled in with `define SD_CMD_INDEX_CHECK_EN.
module sd_cmd_master #(
  parameter int unsigned TO_W = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            write_req_s,
  input  logic [15:0]     cmd_set_s,
  input  logic [31:0]     cmd_arg_s,
  input  logic [TO_W-1:0] timeout_i,
  input  logic [15:0]     nisr_clr_i,
  input  logic [15:0]     eisr_clr_i,
  output logic            ser_req_o,
  output logic [39:0]     ser_frame_o,
  output logic [1:0]      ser_rsp_o,
  input  logic            ser_ack_i,
  input  logic            ser_done_i,
  input  logic [31:0]     ser_rsp_i,
  input  logic [5:0]      ser_idx_i,
  input  logic            ser_crc_ok_i,
  input  logic            ser_busy_i,
  output logic [15:0]     status_reg,
  output logic [31:0]     cmd_resp_1,
  output logic [15:0]     normal_int_status_reg,
  output logic [15:0]     error_int_status_reg
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [TO_W-1:0] cnt;
  logic            crc_en;
  logic            inhibit;
  logic            cc_bit, to_bit, crc_bit, idx_bit;
  logic            timeout_hit, idx_mismatch;
  logic            load_cmd, latch_rsp, crc_set, idx_set, to_set, cc_set;
  logic            unused_bits;

  assign timeout_hit = (timeout_i != '0) && (cnt == timeout_i - TO_W'(1));

`ifdef SD_CMD_INDEX_CHECK_EN
  logic idx_en;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)      idx_en <= 1'b0;
    else if (load_cmd) idx_en <= cmd_set_s[4];
  end

  assign idx_mismatch = idx_en && (ser_idx_i != ser_frame_o[37:32]);
  assign unused_bits  = ^{cmd_set_s[15:14], cmd_set_s[7:5], cmd_set_s[2]};
`else
  assign idx_mismatch = 1'b0;
  assign unused_bits  = ^{cmd_set_s[15:14], cmd_set_s[7:4], cmd_set_s[2], ser_idx_i};
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (write_req_s) state_n = SEND;
      SEND: if (ser_ack_i)   state_n = WAIT;
      WAIT: begin
        if (ser_done_i)       state_n = (ser_rsp_o == 2'b11) ? BUSY : DONE;
        else if (timeout_hit) state_n = DONE;
      end
      BUSY: if (!ser_busy_i) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output/update strobes, registered below
  always_comb begin
    load_cmd  = 1'b0;
    latch_rsp = 1'b0;
    crc_set   = 1'b0;
    idx_set   = 1'b0;
    to_set    = 1'b0;
    cc_set    = 1'b0;
    load_cmd  = (state == IDLE) && write_req_s;
    latch_rsp = (state == WAIT) && ser_done_i && (ser_rsp_o != 2'b00);
    crc_set   = latch_rsp && crc_en && !ser_crc_ok_i;
    idx_set   = latch_rsp && idx_mismatch;
    to_set    = (state == WAIT) && !ser_done_i && timeout_hit;
    cc_set    = (state_n == DONE);
  end

  // Response-timeout counter, saturating, cleared outside WAIT
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != WAIT) cnt <= '0;
    else if (cnt != '1)            cnt <= cnt + TO_W'(1);
  end

  // Frame latch, handshake and status registers; sticky bits: set beats clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ser_req_o   <= 1'b0;
      ser_frame_o <= '0;
      ser_rsp_o   <= '0;
      crc_en      <= 1'b0;
      inhibit     <= 1'b0;
      cmd_resp_1  <= '0;
      cc_bit      <= 1'b0;
      to_bit      <= 1'b0;
      crc_bit     <= 1'b0;
      idx_bit     <= 1'b0;
    end else begin
      if (load_cmd) begin
        ser_frame_o <= {2'b01, cmd_set_s[13:8], cmd_arg_s};
        ser_rsp_o   <= cmd_set_s[1:0];
        crc_en      <= cmd_set_s[3];
      end
      if (latch_rsp) cmd_resp_1 <= ser_rsp_i;
      ser_req_o <= (state_n == SEND);
      inhibit   <= (state_n != IDLE);
      cc_bit    <= cc_set  | (cc_bit  & ~nisr_clr_i[0]);
      to_bit    <= to_set  | (to_bit  & ~eisr_clr_i[0]);
      crc_bit   <= crc_set | (crc_bit & ~eisr_clr_i[1]);
      idx_bit   <= idx_set | (idx_bit & ~eisr_clr_i[3]);
    end
  end

  assign status_reg            = {15'b0, inhibit};
  assign error_int_status_reg  = {12'b0, idx_bit, 1'b0, crc_bit, to_bit};
  assign normal_int_status_reg = {|error_int_status_reg, 14'b0, cc_bit};

endmodule

// File: tb/tb_sd_cmd_master.sv
// Scoreboard bench for sd_cmd_master: stimulus pushes expected frames/completions, a monitor pops and compares.
module tb_sd_cmd_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        write_req_s = 1'b0;
  logic [15:0] cmd_set_s = '0;
  logic [31:0] cmd_arg_s = '0;
  logic [15:0] timeout_i = '0;
  logic [15:0] nisr_clr_i = '0;
  logic [15:0] eisr_clr_i = '0;
  logic        ser_req_o;
  logic [39:0] ser_frame_o;
  logic [1:0]  ser_rsp_o;
  logic        ser_ack_i = 1'b0;
  logic        ser_done_i = 1'b0;
  logic [31:0] ser_rsp_i = '0;
  logic [5:0]  ser_idx_i = '0;
  logic        ser_crc_ok_i = 1'b1;
  logic        ser_busy_i = 1'b0;
  logic [15:0] status_reg;
  logic [31:0] cmd_resp_1;
  logic [15:0] normal_int_status_reg;
  logic [15:0] error_int_status_reg;

  sd_cmd_master #(.TO_W(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .write_req_s(write_req_s),
    .cmd_set_s(cmd_set_s), .cmd_arg_s(cmd_arg_s), .timeout_i(timeout_i),
    .nisr_clr_i(nisr_clr_i), .eisr_clr_i(eisr_clr_i),
    .ser_req_o(ser_req_o), .ser_frame_o(ser_frame_o), .ser_rsp_o(ser_rsp_o),
    .ser_ack_i(ser_ack_i), .ser_done_i(ser_done_i), .ser_rsp_i(ser_rsp_i),
    .ser_idx_i(ser_idx_i), .ser_crc_ok_i(ser_crc_ok_i), .ser_busy_i(ser_busy_i),
    .status_reg(status_reg), .cmd_resp_1(cmd_resp_1),
    .normal_int_status_reg(normal_int_status_reg),
    .error_int_status_reg(error_int_status_reg)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [39:0] frame;
    logic [1:0]  rsp;
  } exp_frame_t;

  typedef struct {
    logic [31:0] resp;
    logic [15:0] nisr;
    logic [15:0] eisr;
  } exp_done_t;

  exp_frame_t frame_q[$];
  exp_done_t  done_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       prev_cc = 1'b0;

`ifdef SD_CMD_INDEX_CHECK_EN
  localparam logic [15:0] EISR_T5 = 16'h000A;
`else
  localparam logic [15:0] EISR_T5 = 16'h0002;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push_frame(input logic [39:0] f, input logic [1:0] r);
    exp_frame_t e;
    e.frame = f; e.rsp = r;
    frame_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] r, input logic [15:0] n, input logic [15:0] e);
    exp_done_t d;
    d.resp = r; d.nisr = n; d.eisr = e;
    done_q.push_back(d);
  endtask

  // Request, hold for ack_dly clocks, then handshake; returns one tick after WAIT entry
  task automatic issue(input logic [15:0] cs, input logic [31:0] arg, input int ack_dly);
    cmd_set_s = cs; cmd_arg_s = arg; write_req_s = 1'b1;
    tick();
    write_req_s = 1'b0;
    check("req_rise", 64'(ser_req_o), 64'd1);
    check("inhibit_set", 64'(status_reg), 64'h1);
    repeat (ack_dly) tick();
    check("req_hold", 64'(ser_req_o), 64'd1);
    ser_ack_i = 1'b1;
    tick();
    ser_ack_i = 1'b0;
    check("req_drop", 64'(ser_req_o), 64'd0);
  endtask

  task automatic done_pulse(input logic [31:0] r, input logic [5:0] idx, input logic ok);
    ser_rsp_i = r; ser_idx_i = idx; ser_crc_ok_i = ok; ser_done_i = 1'b1;
    tick();
    ser_done_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (status_reg[0] && n < 100) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(status_reg[0]), 64'd0);
  endtask

  task automatic clear_all();
    nisr_clr_i = 16'hFFFF; eisr_clr_i = 16'hFFFF;
    tick();
    nisr_clr_i = '0; eisr_clr_i = '0;
  endtask

  // Monitor: compare frames at handshake and completion state at each cmd-complete rise
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (ser_req_o && ser_ack_i) begin
        if (frame_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL frame_unexpected: got %h expected none", ser_frame_o);
        end else begin
          exp_frame_t e;
          e = frame_q.pop_front();
          check("frame", 64'(ser_frame_o), 64'(e.frame));
          check("frame_rsp", 64'(ser_rsp_o), 64'(e.rsp));
        end
      end
      if (normal_int_status_reg[0] && !prev_cc) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: got nisr %h expected none", normal_int_status_reg);
        end else begin
          exp_done_t d;
          d = done_q.pop_front();
          check("cmd_resp_1", 64'(cmd_resp_1), 64'(d.resp));
          check("nisr", 64'(normal_int_status_reg), 64'(d.nisr));
          check("eisr", 64'(error_int_status_reg), 64'(d.eisr));
        end
      end
    end
    prev_cc <= normal_int_status_reg[0];
  end

  initial begin
    logic ok;
    repeat (2) tick();
    wb_rst_i = 1'b0;
    check("rst_req", 64'(ser_req_o), 64'd0);
    check("rst_status", 64'(status_reg), 64'd0);
    check("rst_nisr", 64'(normal_int_status_reg), 64'd0);
    check("rst_eisr", 64'(error_int_status_reg), 64'd0);
    check("rst_frame", 64'(ser_frame_o), 64'd0);

    // 1: reset mid-SEND
    cmd_set_s = 16'h0D1A; cmd_arg_s = 32'h1234_5678; write_req_s = 1'b1;
    tick();
    write_req_s = 1'b0;
    check("t1_req", 64'(ser_req_o), 64'd1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("t1_req_after_rst", 64'(ser_req_o), 64'd0);
    check("t1_frame_after_rst", 64'(ser_frame_o), 64'd0);
    check("t1_status_after_rst", 64'(status_reg), 64'd0);
    tick();
    check("t1_stay_idle", 64'({ser_req_o, status_reg}), 64'd0);

    // 2: basic 48-bit command
    push_frame(40'h4D_1234_5678, 2'b10);
    push_done(32'hCAFE_0900, 16'h0001, 16'h0000);
    issue(16'h0D1A, 32'h1234_5678, 3);
    repeat (2) tick();
    done_pulse(32'hCAFE_0900, 6'h0D, 1'b1);
    wait_idle();
    clear_all();

    // 3: timeout exactly 16 clocks after WAIT entry
    timeout_i = 16'd16;
    push_frame(40'h48_0000_0000, 2'b10);
    push_done(32'hCAFE_0900, 16'h8001, 16'h0001);
    issue(16'h0802, 32'h0000_0000, 0);
    repeat (15) tick();
    check("t3_eisr_before", 64'(error_int_status_reg), 64'd0);
    tick();
    check("t3_eisr_at16", 64'(error_int_status_reg), 64'h0001);
    check("t3_nisr_at16", 64'(normal_int_status_reg), 64'h8001);
    wait_idle();
    timeout_i = '0;
    nisr_clr_i = 16'h0001; eisr_clr_i = 16'h0001;
    tick();
    nisr_clr_i = '0; eisr_clr_i = '0;
    check("t3_nisr_clr", 64'(normal_int_status_reg), 64'd0);
    check("t3_eisr_clr", 64'(error_int_status_reg), 64'd0);

    // 4: R1b busy hold
    push_frame(40'h47_DEAD_BEEF, 2'b11);
    push_done(32'h0000_0900, 16'h0001, 16'h0000);
    issue(16'h070B, 32'hDEAD_BEEF, 1);
    tick();
    ser_busy_i = 1'b1;
    done_pulse(32'h0000_0900, 6'h07, 1'b1);
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (status_reg[0] !== 1'b1 || normal_int_status_reg[0] !== 1'b0) ok = 1'b0;
    end
    check("t4_busy_hold", 64'(ok), 64'd1);
    ser_busy_i = 1'b0;
    tick();
    check("t4_cc_after_busy", 64'(normal_int_status_reg[0]), 64'd1);
    check("t4_inhibit_in_done", 64'(status_reg[0]), 64'd1);
    tick();
    check("t4_inhibit_clear", 64'(status_reg[0]), 64'd0);
    clear_all();

    // 5: CRC bad and index mismatch
    push_frame(40'h4D_0000_0001, 2'b10);
    push_done(32'h1111_2222, 16'h8001, EISR_T5);
    issue(16'h0D1A, 32'h0000_0001, 2);
    done_pulse(32'h1111_2222, 6'h11, 1'b0);
    wait_idle();
    clear_all();

    // 6: ignored write_req in WAIT; W1C in the set clock loses
    push_frame(40'h4A_A5A5_0001, 2'b10);
    push_done(32'h6666_0600, 16'h8001, 16'h0002);
    issue(16'h0A0A, 32'hA5A5_0001, 0);
    write_req_s = 1'b1;
    tick();
    write_req_s = 1'b0;
    nisr_clr_i = 16'h0001; eisr_clr_i = 16'h0002;
    done_pulse(32'h6666_0600, 6'h0A, 1'b0);
    nisr_clr_i = '0; eisr_clr_i = '0;
    wait_idle();
    repeat (5) tick();
    check("t6_no_second_req", 64'({ser_req_o, status_reg[0]}), 64'd0);
    check("t6_sticky_nisr", 64'(normal_int_status_reg), 64'h8001);
    clear_all();

    // 7: type 00 keeps old response and skips checks
    push_frame(40'h45_0000_00FF, 2'b00);
    push_done(32'h6666_0600, 16'h0001, 16'h0000);
    issue(16'h0508, 32'h0000_00FF, 1);
    done_pulse(32'hFFFF_FFFF, 6'h3F, 1'b0);
    wait_idle();
    clear_all();

    repeat (3) tick();
    check("frames_pending", 64'(frame_q.size()), 64'd0);
    check("dones_pending", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
